// File: rtl/moxie_wb_arbiter_pkg.sv
// Shared definitions for the moxie Wishbone two-master arbiter: grant-state
// encodings, master identifiers, default timeout and the idle-state arbitration rule.
// Optional build macro honoured by the arbiter: MOXIE_WB_TIMEOUT_EN.
package moxie_wb_arbiter_pkg;

  typedef enum logic [1:0] {
    WBA_IDLE  = 2'd0,
    WBA_GNT_I = 2'd1,
    WBA_GNT_D = 2'd2
  } wba_state_e;

  typedef enum logic {
    MST_I = 1'b0,
    MST_D = 1'b1
  } wba_mst_e;

  localparam int unsigned WBA_TIMEOUT_DEF = 255;

  // Grant decision taken in IDLE; a tie goes to the master that was not served last.
  function automatic wba_state_e wba_pick(input logic req_i, input logic req_d,
                                          input wba_mst_e last);
    wba_state_e nxt;
    nxt = WBA_IDLE;
    if (req_i && req_d) nxt = (last == MST_I) ? WBA_GNT_D : WBA_GNT_I;
    else if (req_d)     nxt = WBA_GNT_D;
    else if (req_i)     nxt = WBA_GNT_I;
    return nxt;
  endfunction

endpackage

// File: rtl/moxie_wb_timeout.sv
// Grant watchdog: counts granted cycles without a slave ack and flags expiry.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   busy       a grant is active this cycle (count clears while low)
//   ack        slave ack this cycle (an ack on the limit cycle suppresses expiry)
//   expire_c   combinational, high for the cycle in which count reaches TIMEOUT
// TIMEOUT must be at least 1.
module moxie_wb_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic ack,
  output logic expire_c
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count;

  // Saturating wait counter, restarted whenever no grant is active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!busy) begin
      count <= '0;
    end else if (!ack && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign expire_c = busy & ~ack & (count == LIMIT);

endmodule

// File: rtl/moxie_wb_arbiter.sv
// Two-master / one-slave Wishbone classic arbiter merging the core's instruction (mi_*)
// and data (md_*) ports onto one shared bus. Round-robin grant, one single-beat transfer
// per grant, slave-side fields muxed combinationally from the registered grant state.
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   mi_* / md_* inputs                 master address, write data, select, we, cyc, stb
//   mi_dat_o/ack_o/err_o, md_*_o       per-master read data (valid with ack), ack, error
//   s_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o  shared slave bus, driven by the granted master
//   s_dat_i, s_ack_i                   slave read data and ack
// Build macro MOXIE_WB_TIMEOUT_EN: adds the TIMEOUT parameter and a watchdog that errors
// out a grant the slave never acks. Without it the err outputs are tied low.
module moxie_wb_arbiter
  import moxie_wb_arbiter_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned SW = DW / 8
`ifdef MOXIE_WB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = WBA_TIMEOUT_DEF
`endif
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] mi_adr_i,
  input  logic [DW-1:0] mi_dat_i,
  input  logic [SW-1:0] mi_sel_i,
  input  logic          mi_we_i,
  input  logic          mi_cyc_i,
  input  logic          mi_stb_i,
  output logic [DW-1:0] mi_dat_o,
  output logic          mi_ack_o,
  output logic          mi_err_o,
  input  logic [AW-1:0] md_adr_i,
  input  logic [DW-1:0] md_dat_i,
  input  logic [SW-1:0] md_sel_i,
  input  logic          md_we_i,
  input  logic          md_cyc_i,
  input  logic          md_stb_i,
  output logic [DW-1:0] md_dat_o,
  output logic          md_ack_o,
  output logic          md_err_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic [SW-1:0] s_sel_o,
  output logic          s_we_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i
);

  wba_state_e state;
  wba_mst_e   last;
  logic       req_i, req_d;
  logic       expire_c;

  assign req_i = mi_cyc_i & mi_stb_i;
  assign req_d = md_cyc_i & md_stb_i;

`ifdef MOXIE_WB_TIMEOUT_EN
  moxie_wb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk_i),
    .rst      (rst_i),
    .busy     (state != WBA_IDLE),
    .ack      (s_ack_i),
    .expire_c (expire_c)
  );
`else
  assign expire_c = 1'b0;
`endif

  // Grant FSM: a grant ends on ack, abort (granted cyc dropped) or watchdog expiry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= WBA_IDLE;
      last  <= MST_I;
    end else begin
      case (state)
        WBA_IDLE: state <= wba_pick(req_i, req_d, last);
        WBA_GNT_I: begin
          if (s_ack_i || !mi_cyc_i || expire_c) begin
            state <= WBA_IDLE;
            last  <= MST_I;
          end
        end
        WBA_GNT_D: begin
          if (s_ack_i || !md_cyc_i || expire_c) begin
            state <= WBA_IDLE;
            last  <= MST_D;
          end
        end
        default: state <= WBA_IDLE;
      endcase
    end
  end

  // Slave-side mux and master responses, decoded from the registered grant.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    mi_ack_o = 1'b0;
    mi_err_o = 1'b0;
    md_ack_o = 1'b0;
    md_err_o = 1'b0;
    case (state)
      WBA_GNT_I: begin
        s_adr_o  = mi_adr_i;
        s_dat_o  = mi_dat_i;
        s_sel_o  = mi_sel_i;
        s_we_o   = mi_we_i;
        s_cyc_o  = mi_cyc_i & ~expire_c;
        s_stb_o  = mi_stb_i & ~expire_c;
        mi_ack_o = s_ack_i & mi_cyc_i;
        mi_err_o = expire_c;
      end
      WBA_GNT_D: begin
        s_adr_o  = md_adr_i;
        s_dat_o  = md_dat_i;
        s_sel_o  = md_sel_i;
        s_we_o   = md_we_i;
        s_cyc_o  = md_cyc_i & ~expire_c;
        s_stb_o  = md_stb_i & ~expire_c;
        md_ack_o = s_ack_i & md_cyc_i;
        md_err_o = expire_c;
      end
      default: ;
    endcase
    // Read data only presented alongside that master's ack.
    mi_dat_o = mi_ack_o ? s_dat_i : '0;
    md_dat_o = md_ack_o ? s_dat_i : '0;
  end

endmodule
